// File: rtl/packet_framer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | packet_framer_ctrl : STP/SDP framed packet extractor with END/EDB close |
// | Optional: PKT_LEN_CHECK_EN enables DLLP/TLP length checking            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module packet_framer_ctrl #(
  parameter int MAX_TLP_BYTES = 1036
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        DK,
  input  logic        valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [1:0]  pkt_kind,
  output logic        sop,
  output logic        eop,
  output logic        eop_good,
  output logic        eop_nullified,
  output logic        framing_err,
  output logic        len_err,
  output logic [10:0] pkt_len
);

  localparam logic [7:0]  K_STP    = 8'hFB;
  localparam logic [7:0]  K_SDP    = 8'h5C;
  localparam logic [7:0]  K_END    = 8'hFD;
  localparam logic [7:0]  K_EDB    = 8'hFE;
  localparam logic [7:0]  K_PAD    = 8'hF7;
  localparam logic [1:0]  KIND_TLP = 2'b01;
  localparam logic [1:0]  KIND_DLP = 2'b10;
  localparam logic [10:0] DLLP_LEN = 11'd6;
  localparam logic [10:0] CNT_MAX  = 11'h7FF;
  localparam logic [10:0] MAX_CNT  = 11'(MAX_TLP_BYTES);

`ifdef PKT_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TLP  = 2'd1,
    DLLP = 2'd2
  } state_t;

  state_t      state;
  logic [10:0] cnt;

  logic        is_stp, is_sdp, is_end, is_edb, is_pad;
  logic        in_tlp;
  logic [10:0] cnt_inc;

  assign is_stp  = DK && (data_in == K_STP);
  assign is_sdp  = DK && (data_in == K_SDP);
  assign is_end  = DK && (data_in == K_END);
  assign is_edb  = DK && (data_in == K_EDB);
  assign is_pad  = DK && (data_in == K_PAD);
  assign in_tlp  = (state == TLP);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 11'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      byte_out      <= '0;
      byte_valid    <= 1'b0;
      pkt_kind      <= 2'b00;
      sop           <= 1'b0;
      eop           <= 1'b0;
      eop_good      <= 1'b0;
      eop_nullified <= 1'b0;
      framing_err   <= 1'b0;
      len_err       <= 1'b0;
      pkt_len       <= '0;
    end else begin
      // Pulse outputs default low; only the branch that fires raises them.
      byte_out      <= '0;
      byte_valid    <= 1'b0;
      sop           <= 1'b0;
      eop           <= 1'b0;
      eop_good      <= 1'b0;
      eop_nullified <= 1'b0;
      framing_err   <= 1'b0;
      len_err       <= 1'b0;
      pkt_len       <= '0;

      case (state)
        IDLE: begin
          pkt_kind <= 2'b00;
          if (valid) begin
            if (is_stp) begin
              state    <= TLP;
              sop      <= 1'b1;
              pkt_kind <= KIND_TLP;
              cnt      <= '0;
            end else if (is_sdp) begin
              state    <= DLLP;
              sop      <= 1'b1;
              pkt_kind <= KIND_DLP;
              cnt      <= '0;
            end else if (is_end || is_edb) begin
              framing_err <= 1'b1;
            end
          end
        end

        TLP, DLLP: begin
          // kind stays with the packet through its eop cycle
          pkt_kind <= in_tlp ? KIND_TLP : KIND_DLP;
          if (valid) begin
            if (!DK) begin
              if (LEN_CHECK && in_tlp && (cnt >= MAX_CNT)) begin
                eop     <= 1'b1;
                len_err <= 1'b1;
                pkt_len <= cnt;
                state   <= IDLE;
              end else begin
                byte_out   <= data_in;
                byte_valid <= 1'b1;
                cnt        <= cnt_inc;
              end
            end else if (is_end) begin
              eop     <= 1'b1;
              pkt_len <= cnt;
              state   <= IDLE;
              if (LEN_CHECK && !in_tlp && (cnt != DLLP_LEN)) begin
                len_err <= 1'b1;
              end else begin
                eop_good <= 1'b1;
              end
            end else if (is_edb) begin
              eop     <= 1'b1;
              pkt_len <= cnt;
              state   <= IDLE;
              if (in_tlp) begin
                eop_nullified <= 1'b1;
              end else begin
                framing_err <= 1'b1;
              end
            end else if (is_stp || is_sdp || is_pad) begin
              // aborting symbol closes the packet and does not open a new one
              eop         <= 1'b1;
              framing_err <= 1'b1;
              pkt_len     <= cnt;
              state       <= IDLE;
            end
          end
        end

        default: begin
          state    <= IDLE;
          pkt_kind <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_framer_ctrl.sv
`default_nettype none
// Directed testbench for packet_framer_ctrl; honours PKT_LEN_CHECK_EN.
module tb_packet_framer_ctrl;

`ifdef PKT_LEN_CHECK_EN
  localparam int MAXB  = 8;
  localparam int TLP_N = 8;
`else
  localparam int MAXB  = 1036;
  localparam int TLP_N = 12;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = '0;
  logic        DK = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [1:0]  pkt_kind;
  logic        sop, eop, eop_good, eop_nullified, framing_err, len_err;
  logic [10:0] pkt_len;

  int errors = 0;
  int checks = 0;

  packet_framer_ctrl #(.MAX_TLP_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .DK(DK), .valid(valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .pkt_kind(pkt_kind),
    .sop(sop), .eop(eop), .eop_good(eop_good), .eop_nullified(eop_nullified),
    .framing_err(framing_err), .len_err(len_err), .pkt_len(pkt_len)
  );

  always #5 clk = ~clk;

  // Flags packed as {sop,eop,eop_good,eop_nullified,framing_err,len_err,byte_valid}
  wire [6:0] flags = {sop, eop, eop_good, eop_nullified, framing_err, len_err, byte_valid};

  task automatic step(input logic k, input logic [7:0] d, input logic v);
    DK = k; data_in = d; valid = v;
    @(posedge clk); #1;
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b0, base + 8'(i), 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b1, 8'hFB, 1'b1);
    checks++;
    if ({byte_out, pkt_kind, flags, pkt_len} !== 28'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {byte_out, pkt_kind, flags, pkt_len});
    end
    rst = 1'b0;
    step(1'b0, 8'h55, 1'b1);
    checks++;
    if (flags !== 7'b0) begin
      errors++; $display("FAIL reset_idle_data: flags got %b expected 0000000", flags);
    end
  endtask

  task automatic test_tlp;
    step(1'b1, 8'hFB, 1'b1);
    checks++;
    if (flags !== 7'b1000000 || pkt_kind !== 2'b01) begin
      errors++; $display("FAIL tlp_sop: flags=%b kind=%b expected 1000000/01", flags, pkt_kind);
    end
    for (int i = 0; i < TLP_N; i++) begin
      step(1'b0, 8'(i), 1'b1);
      checks++;
      if (flags !== 7'b0000001 || byte_out !== 8'(i) || pkt_kind !== 2'b01) begin
        errors++; $display("FAIL tlp_byte%0d: flags=%b byte=%h kind=%b expected 0000001/%h/01", i, flags, byte_out, pkt_kind, 8'(i));
      end
    end
    step(1'b1, 8'hFD, 1'b1);
    checks++;
    if (flags !== 7'b0110000 || pkt_len !== 11'(TLP_N) || pkt_kind !== 2'b01) begin
      errors++; $display("FAIL tlp_eop: flags=%b len=%0d kind=%b expected 0110000/%0d/01", flags, pkt_len, pkt_kind, TLP_N);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (flags !== 7'b0 || pkt_kind !== 2'b00 || pkt_len !== 11'd0) begin
      errors++; $display("FAIL tlp_after_eop: flags=%b kind=%b len=%0d expected 0/00/0", flags, pkt_kind, pkt_len);
    end
  endtask

  task automatic test_dllp;
    step(1'b1, 8'h5C, 1'b1);
    checks++;
    if (sop !== 1'b1 || pkt_kind !== 2'b10) begin
      errors++; $display("FAIL dllp_sop: sop=%b kind=%b expected 1/10", sop, pkt_kind);
    end
    send_bytes(6, 8'hA0);
    checks++;
    if (byte_out !== 8'hA5 || byte_valid !== 1'b1) begin
      errors++; $display("FAIL dllp_last_byte: byte=%h bv=%b expected a5/1", byte_out, byte_valid);
    end
    step(1'b1, 8'hFD, 1'b1);
    checks++;
    if (flags !== 7'b0110000 || pkt_len !== 11'd6 || pkt_kind !== 2'b10) begin
      errors++; $display("FAIL dllp6_eop: flags=%b len=%0d kind=%b expected 0110000/6/10", flags, pkt_len, pkt_kind);
    end
    step(1'b1, 8'h5C, 1'b1);
    send_bytes(5, 8'h10);
    step(1'b1, 8'hFD, 1'b1);
    checks++;
`ifdef PKT_LEN_CHECK_EN
    if (flags !== 7'b0100010 || pkt_len !== 11'd5) begin
      errors++; $display("FAIL dllp5_eop: flags=%b len=%0d expected 0100010/5", flags, pkt_len);
    end
`else
    if (flags !== 7'b0110000 || pkt_len !== 11'd5) begin
      errors++; $display("FAIL dllp5_eop: flags=%b len=%0d expected 0110000/5", flags, pkt_len);
    end
`endif
  endtask

  task automatic test_edb;
    step(1'b1, 8'hFB, 1'b1);
    send_bytes(4, 8'h40);
    step(1'b1, 8'hFE, 1'b1);
    checks++;
    if (flags !== 7'b0101000 || pkt_len !== 11'd4 || pkt_kind !== 2'b01) begin
      errors++; $display("FAIL tlp_edb: flags=%b len=%0d kind=%b expected 0101000/4/01", flags, pkt_len, pkt_kind);
    end
    step(1'b1, 8'hFD, 1'b1);
    checks++;
    if (flags !== 7'b0000100 || pkt_kind !== 2'b00) begin
      errors++; $display("FAIL idle_end: flags=%b kind=%b expected 0000100/00", flags, pkt_kind);
    end
    step(1'b1, 8'h5C, 1'b1);
    send_bytes(2, 8'h20);
    step(1'b1, 8'hFE, 1'b1);
    checks++;
    if (flags !== 7'b0100100 || pkt_kind !== 2'b10) begin
      errors++; $display("FAIL dllp_edb: flags=%b kind=%b expected 0100100/10", flags, pkt_kind);
    end
  endtask

  task automatic test_abort;
    step(1'b1, 8'hFB, 1'b1);
    send_bytes(3, 8'h30);
    step(1'b1, 8'h5C, 1'b1);
    checks++;
    if (flags !== 7'b0100100 || pkt_len !== 11'd3 || pkt_kind !== 2'b01) begin
      errors++; $display("FAIL abort_sdp: flags=%b len=%0d kind=%b expected 0100100/3/01", flags, pkt_len, pkt_kind);
    end
    step(1'b0, 8'h77, 1'b1);
    checks++;
    if (flags !== 7'b0 || pkt_kind !== 2'b00) begin
      errors++; $display("FAIL abort_then_idle: flags=%b kind=%b expected 0/00", flags, pkt_kind);
    end
    step(1'b1, 8'hF7, 1'b1);
    checks++;
    if (flags !== 7'b0) begin
      errors++; $display("FAIL idle_pad: flags=%b expected 0", flags);
    end
    // Unknown K-symbol inside a packet is ignored and does not count
    step(1'b1, 8'h5C, 1'b1);
    step(1'b0, 8'h01, 1'b1);
    step(1'b1, 8'h1C, 1'b1);
    checks++;
    if (flags !== 7'b0 || pkt_kind !== 2'b10) begin
      errors++; $display("FAIL unknown_k: flags=%b kind=%b expected 0/10", flags, pkt_kind);
    end
    step(1'b1, 8'hF7, 1'b1);
    checks++;
    if (flags !== 7'b0100100 || pkt_len !== 11'd1) begin
      errors++; $display("FAIL abort_pad: flags=%b len=%0d expected 0100100/1", flags, pkt_len);
    end
  endtask

  task automatic test_gaps;
    step(1'b1, 8'hFB, 1'b1);
    step(1'b0, 8'h01, 1'b1);
    step(1'b1, 8'hFD, 1'b0);
    checks++;
    if (flags !== 7'b0 || pkt_kind !== 2'b01) begin
      errors++; $display("FAIL gap_hold: flags=%b kind=%b expected 0/01", flags, pkt_kind);
    end
    step(1'b0, 8'h02, 1'b1);
    step(1'b0, 8'h99, 1'b0);
    step(1'b1, 8'hFB, 1'b0);
    step(1'b0, 8'h03, 1'b1);
    step(1'b1, 8'hFD, 1'b1);
    checks++;
    if (flags !== 7'b0110000 || pkt_len !== 11'd3) begin
      errors++; $display("FAIL gap_len: flags=%b len=%0d expected 0110000/3", flags, pkt_len);
    end
  endtask

  task automatic test_rst_mid;
    step(1'b1, 8'hFB, 1'b1);
    send_bytes(5, 8'h50);
    rst = 1'b1;
    step(1'b1, 8'hFD, 1'b1);
    checks++;
    if ({byte_out, pkt_kind, flags, pkt_len} !== 28'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h expected 0", {byte_out, pkt_kind, flags, pkt_len});
    end
    rst = 1'b0;
    step(1'b0, 8'h66, 1'b1);
    checks++;
    if (flags !== 7'b0) begin
      errors++; $display("FAIL rst_mid_dropped: flags=%b expected 0", flags);
    end
    step(1'b1, 8'h5C, 1'b1);
    send_bytes(6, 8'h60);
    step(1'b1, 8'hFD, 1'b1);
    checks++;
    if (flags !== 7'b0110000 || pkt_len !== 11'd6 || pkt_kind !== 2'b10) begin
      errors++; $display("FAIL rst_next_pkt: flags=%b len=%0d kind=%b expected 0110000/6/10", flags, pkt_len, pkt_kind);
    end
  endtask

  task automatic test_length;
`ifdef PKT_LEN_CHECK_EN
    step(1'b1, 8'hFB, 1'b1);
    send_bytes(8, 8'h80);
    step(1'b0, 8'h88, 1'b1);
    checks++;
    if (flags !== 7'b0100010 || byte_out !== 8'h00) begin
      errors++; $display("FAIL tlp_overlen: flags=%b byte=%h expected 0100010/00", flags, byte_out);
    end
    step(1'b0, 8'h89, 1'b1);
    checks++;
    if (flags !== 7'b0 || pkt_kind !== 2'b00) begin
      errors++; $display("FAIL tlp_overlen_idle: flags=%b kind=%b expected 0/00", flags, pkt_kind);
    end
`else
    // Count saturates at 2047 with no length-based abort
    step(1'b1, 8'hFB, 1'b1);
    send_bytes(2050, 8'h00);
    checks++;
    if (flags !== 7'b0000001) begin
      errors++; $display("FAIL long_tlp_forward: flags=%b expected 0000001", flags);
    end
    step(1'b1, 8'hFD, 1'b1);
    checks++;
    if (flags !== 7'b0110000 || pkt_len !== 11'd2047) begin
      errors++; $display("FAIL saturate: flags=%b len=%0d expected 0110000/2047", flags, pkt_len);
    end
`endif
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_tlp;
    test_dllp;
    test_edb;
    test_abort;
    test_gaps;
    test_rst_mid;
    test_length;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/packet_framer_ctrl.md
PACKET_FRAMER_CTRL -- requirements
Module: packet_framer_ctrl

Interface
REQ-001 SHALL have parameter MAX_TLP_BYTES, default 1036, maximum TLP data bytes between STP and END/EDB.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- data_in  in  8  received symbol
- DK  in  1  1 = data_in is a K-symbol, 0 = data byte
- valid  in  1  symbol qualifier
- byte_out  out  8  registered payload byte
- byte_valid  out  1  byte_out is packet payload
- pkt_kind  out  2  01 TLP, 10 DLLP, 00 none; packet owning the current output
- sop  out  1  one-cycle start-of-packet pulse
- eop  out  1  one-cycle end-of-packet pulse
- eop_good  out  1  with eop: packet closed by END
- eop_nullified  out  1  with eop: TLP closed by EDB
- framing_err  out  1  one-cycle framing violation pulse
- len_err  out  1  one-cycle length violation pulse
- pkt_len  out  11  data-byte count of the closing packet, valid while eop=1

Function
REQ-003 SHALL decode K-symbols STP=0xFB, SDP=0x5C, END=0xFD, EDB=0xFE, PAD=0xF7; any other K-symbol SHALL be ignored.
REQ-004 SHALL implement FSM states IDLE, TLP, DLLP.
REQ-005 All outputs SHALL be registered, one clk after the qualifying input.
REQ-006 With valid=0, state and counter SHALL hold, and byte_valid, sop, eop, framing_err, len_err SHALL be 0 next cycle.
REQ-007 In IDLE:
- STP -> TLP, sop=1, pkt_kind=01.
- SDP -> DLLP, sop=1, pkt_kind=10.
- END or EDB -> framing_err=1, stay IDLE.
- data bytes and PAD -> ignored, byte_valid=0.
REQ-008 In TLP or DLLP, each data byte SHALL drive byte_out=data_in and byte_valid=1, and SHALL increment the length counter.
REQ-009 The length counter SHALL saturate at 2047.
REQ-010 END in TLP or DLLP -> eop=1, eop_good=1, pkt_len=count, IDLE.
REQ-011 EDB in TLP -> eop=1, eop_nullified=1, pkt_len=count, IDLE.
REQ-012 EDB in DLLP -> eop=1, framing_err=1, eop_good=0, IDLE.
REQ-013 STP, SDP or PAD inside a packet SHALL abort it: eop=1, framing_err=1, eop_good=0, eop_nullified=0, IDLE. The aborting symbol SHALL NOT start a new packet.
REQ-014 pkt_kind SHALL remain at the packet value through the eop cycle and return to 00 the cycle after.
REQ-015 The counter SHALL clear on every sop.
REQ-016 eop_good, eop_nullified and pkt_len SHALL be 0 whenever eop=0.

Reset
REQ-017 On rst=1 at a clk edge:
- state SHALL go to IDLE and the counter to 0.
- all outputs SHALL be 0.
- any in-flight packet SHALL be dropped without eop.
REQ-018 rst SHALL take priority over valid in the same cycle.

Configuration
REQ-019 Macro PKT_LEN_CHECK_EN SHALL enable length checking when defined.
REQ-020 With PKT_LEN_CHECK_EN defined:
- A DLLP closed by END with count != 6 SHALL assert len_err=1 with eop, and eop_good=0.
- A TLP data byte that would make count exceed MAX_TLP_BYTES SHALL assert len_err=1 and eop=1 with eop_good=0, SHALL NOT be forwarded, and the FSM SHALL go to IDLE.
REQ-021 Without PKT_LEN_CHECK_EN, len_err SHALL be tied 0 and no length-based abort SHALL occur.

Verification
REQ-022 STP, 12 data bytes 0x00..0x0B, END (DK correct) -> sop@1, 12 byte_valid cycles with pkt_kind=01, eop+eop_good with pkt_len=12.
REQ-023 SDP, 6 data bytes, END -> pkt_kind=10, eop_good=1, pkt_len=6, len_err=0. Same with 5 bytes under PKT_LEN_CHECK_EN -> len_err=1, eop_good=0.
REQ-024 STP, 4 data bytes, EDB -> eop=1, eop_nullified=1, pkt_len=4. END in IDLE -> framing_err=1 only.
REQ-025 STP, 3 data bytes, SDP -> eop=1, framing_err=1, no sop for the SDP, state IDLE. valid=0 gaps mid-packet -> byte count unaffected.
REQ-026 rst=1 mid-TLP after 5 bytes, then SDP, 6 bytes, END -> no eop for the TLP, next packet reports pkt_len=6. MAX_TLP_BYTES=8 with 9 data bytes under the macro -> len_err on the 9th byte.
